renkon_layer_sched: RTL and testbench

//  Layer scheduler in front of renkon_top. Holds a host-written table of conv/pool layer descriptors.
//  On start, it runs layers 0..n_layer-1 back-to-back. For each layer it drives renkon_top's config

---
 rtl/renkon_sched_pkg.sv | 33 +++
 rtl/renkon_layer_sched_desc_table.sv | 27 ++
 rtl/renkon_layer_sched.sv | 165 ++++++++++++++++
 tb/tb_renkon_layer_sched.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/renkon_sched_pkg.sv
// Shared types for the renkon layer scheduler: descriptor layout, FSM states
// and the saturating counter helper.
package renkon_sched_pkg;

  localparam int LWIDTH  = 16;
  localparam int IMGSIZE = 12;
  localparam int NETSIZE = 12;

  typedef struct packed {
    logic [LWIDTH-1:0]  total_out;
    logic [LWIDTH-1:0]  total_in;
    logic [LWIDTH-1:0]  img_size;
    logic [LWIDTH-1:0]  fil_size;
    logic [LWIDTH-1:0]  pool_size;
    logic [IMGSIZE-1:0] input_addr;
    logic [IMGSIZE-1:0] output_addr;
    logic [NETSIZE-1:0] net_addr;
  } layer_desc_t;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    REQ  = 3'd2,
    WAIT = 3'd3,
    NEXT = 3'd4,
    DONE = 3'd5
  } sched_state_t;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/renkon_layer_sched_desc_table.sv
// Descriptor register file: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset; the host programs them before a run.
module renkon_desc_table
  import renkon_sched_pkg::*;
#(
  parameter int N_LAYER = 8
) (
  input  logic                       clk_i,
  input  logic                       we_i,
  input  logic [$clog2(N_LAYER)-1:0] wr_idx_i,
  input  layer_desc_t                wr_desc_i,
  input  logic [$clog2(N_LAYER)-1:0] rd_idx_i,
  output layer_desc_t                rd_desc_o
);

  layer_desc_t mem_q [N_LAYER];

  // Host write port
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[wr_idx_i] <= wr_desc_i;
    end
  end

  assign rd_desc_o = mem_q[rd_idx_i];

endmodule

// File: rtl/renkon_layer_sched.sv
// Layer scheduler: walks the descriptor table, hands each layer to renkon_top as a
// req/ack transaction, and reports one done/err pulse per run.
module renkon_layer_sched
  import renkon_sched_pkg::*;
#(
  parameter int N_LAYER = 8,
  parameter int TIMEOUT = 2**20
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cfg_we,
  input  logic [$clog2(N_LAYER)-1:0] cfg_idx,
  input  layer_desc_t                cfg_desc,
  input  logic                       start,
  input  logic [$clog2(N_LAYER):0]   n_layer,
  input  logic                       abort,
  output logic                       busy,
  output logic                       done,
  output logic                       err,
  output logic [$clog2(N_LAYER)-1:0] cur_layer,
  output logic [31:0]                layer_cycles,
  output logic                       req,
  output logic [LWIDTH-1:0]          total_out,
  output logic [LWIDTH-1:0]          total_in,
  output logic [LWIDTH-1:0]          img_size,
  output logic [LWIDTH-1:0]          fil_size,
  output logic [LWIDTH-1:0]          pool_size,
  output logic [IMGSIZE-1:0]         input_addr,
  output logic [IMGSIZE-1:0]         output_addr,
  output logic [NETSIZE-1:0]         net_addr,
  input  logic                       ack
);

  localparam int IW = $clog2(N_LAYER);
  localparam int NW = IW + 1;

  sched_state_t  state_q;
  layer_desc_t   cfg_q;
  layer_desc_t   rd_desc;
  logic [IW-1:0] cur_layer_q;
  logic [NW-1:0] n_q;
  logic [NW-1:0] n_clamp_d;
  logic [31:0]   wait_cnt_q;
  logic [31:0]   wait_cnt_d;
  logic [31:0]   layer_cycles_q;
  logic          busy_q;
  logic          done_q;
  logic          err_q;
  logic          req_q;
  logic          tbl_we;
  logic          more_layers;

  // The table is frozen while a run is active so a layer cannot change under renkon_top.
  assign tbl_we      = cfg_we && (state_q == IDLE);
  assign n_clamp_d   = (n_layer > NW'(N_LAYER)) ? NW'(N_LAYER) : n_layer;
  assign wait_cnt_d  = sat_inc32(wait_cnt_q);
  assign more_layers = (NW'(cur_layer_q) + NW'(1)) < n_q;

  renkon_desc_table #(.N_LAYER(N_LAYER)) u_table (
    .clk_i     (clk),
    .we_i      (tbl_we),
    .wr_idx_i  (cfg_idx),
    .wr_desc_i (cfg_desc),
    .rd_idx_i  (cur_layer_q),
    .rd_desc_o (rd_desc)
  );

  // Run FSM with registered status, handshake and config outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      cfg_q          <= '0;
      cur_layer_q    <= '0;
      n_q            <= '0;
      wait_cnt_q     <= 32'd0;
      layer_cycles_q <= 32'd0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      err_q          <= 1'b0;
      req_q          <= 1'b0;
    end else begin
      req_q  <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      // Abort takes priority over a same-cycle ack, so no layer_cycles latch.
      if (abort && (state_q != IDLE) && (state_q != DONE)) begin
        state_q <= DONE;
        done_q  <= 1'b1;
        err_q   <= 1'b1;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (start) begin
              cur_layer_q <= '0;
              n_q         <= n_clamp_d;
              if (n_clamp_d == '0) begin
                state_q <= DONE;
                done_q  <= 1'b1;
              end else begin
                state_q <= LOAD;
                busy_q  <= 1'b1;
              end
            end
          end
          LOAD: begin
            cfg_q   <= rd_desc;
            req_q   <= 1'b1;
            state_q <= REQ;
          end
          REQ: begin
            wait_cnt_q <= 32'd0;
            state_q    <= WAIT;
          end
          WAIT: begin
            if (ack) begin
              layer_cycles_q <= wait_cnt_d;
              state_q        <= NEXT;
            end else if (wait_cnt_d == 32'(TIMEOUT)) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              wait_cnt_q <= wait_cnt_d;
            end
          end
          NEXT: begin
            if (more_layers) begin
              cur_layer_q <= cur_layer_q + IW'(1);
              state_q     <= LOAD;
            end else begin
              state_q <= DONE;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
            end
          end
          DONE: begin
            state_q <= IDLE;
          end
          default: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign err          = err_q;
  assign req          = req_q;
  assign cur_layer    = cur_layer_q;
  assign layer_cycles = layer_cycles_q;
  assign total_out    = cfg_q.total_out;
  assign total_in     = cfg_q.total_in;
  assign img_size     = cfg_q.img_size;
  assign fil_size     = cfg_q.fil_size;
  assign pool_size    = cfg_q.pool_size;
  assign input_addr   = cfg_q.input_addr;
  assign output_addr  = cfg_q.output_addr;
  assign net_addr     = cfg_q.net_addr;

endmodule

// File: tb/tb_renkon_layer_sched.sv
// Directed + randomized bench for renkon_layer_sched with an inline renkon_top ack stub
// and a table/timing reference model.
module tb_renkon_layer_sched;
  import renkon_sched_pkg::*;

  localparam int NL = 8;
  localparam int TO = 100;

  logic clk = 1'b0;
  logic rst, cfg_we, start, abort, ack;
  logic [2:0] cfg_idx;
  layer_desc_t cfg_desc;
  logic [3:0] n_layer;
  logic busy, done, err, req;
  logic [2:0] cur_layer;
  logic [31:0] layer_cycles;
  logic [LWIDTH-1:0] total_out, total_in, img_size, fil_size, pool_size;
  logic [IMGSIZE-1:0] input_addr, output_addr;
  logic [NETSIZE-1:0] net_addr;

  layer_desc_t model_tab [NL];
  int dly [NL];
  int tests = 0;
  int fails = 0;
  logic pend_we;
  layer_desc_t pend_desc;
  logic busy_write;

  always #5 clk = ~clk;

  renkon_layer_sched #(.N_LAYER(NL), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_desc(cfg_desc),
    .start(start), .n_layer(n_layer), .abort(abort), .busy(busy), .done(done), .err(err),
    .cur_layer(cur_layer), .layer_cycles(layer_cycles), .req(req),
    .total_out(total_out), .total_in(total_in), .img_size(img_size), .fil_size(fil_size),
    .pool_size(pool_size), .input_addr(input_addr), .output_addr(output_addr),
    .net_addr(net_addr), .ack(ack)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic layer_desc_t rand_desc();
    layer_desc_t d;
    d.total_out   = LWIDTH'($urandom);
    d.total_in    = LWIDTH'($urandom);
    d.img_size    = LWIDTH'($urandom);
    d.fil_size    = LWIDTH'($urandom);
    d.pool_size   = LWIDTH'($urandom);
    d.input_addr  = IMGSIZE'($urandom);
    d.output_addr = IMGSIZE'($urandom);
    d.net_addr    = NETSIZE'($urandom);
    return d;
  endfunction

  function automatic layer_desc_t obs_cfg();
    return layer_desc_t'({total_out, total_in, img_size, fil_size, pool_size,
                          input_addr, output_addr, net_addr});
  endfunction

  task automatic rand_dly(input int lo, input int hi);
    for (int i = 0; i < NL; i++) dly[i] = int'($urandom_range(hi, lo));
  endtask

  // Start a run of n layers; the stub acks layer k dly[k] cycles after req is seen.
  task automatic run_layers(input int n);
    int ne;
    int spur;
    ne = (n > NL) ? NL : n;
    cfg_we = pend_we; cfg_idx = 3'd0; cfg_desc = pend_desc;
    if (pend_we) model_tab[0] = pend_desc;
    start = 1'b1; n_layer = 4'(n);
    tick();
    start = 1'b0; cfg_we = 1'b0; pend_we = 1'b0;
    if (ne == 0) begin
      chk("zero_done", done, 1);
      chk("zero_err", err, 0);
      chk("zero_req", req, 0);
      chk("zero_busy", busy, 0);
      tick();
      chk("zero_after", {done, req, busy}, 0);
    end else begin
      chk("start_busy", busy, 1);
      for (int k = 0; k < ne; k++) begin
        tick();
        chk("req_pulse", req, 1);
        chk("cur_layer", cur_layer, k);
        chk("cfg_at_req", obs_cfg(), model_tab[k]);
        spur = 0;
        for (int j = 1; j <= dly[k]; j++) begin
          ack = (j == 1);
          if (busy_write && k == 0 && j <= 2) begin
            cfg_we = 1'b1; cfg_idx = 3'(j - 1); cfg_desc = rand_desc();
          end else begin
            cfg_we = 1'b0;
          end
          tick();
          if (req !== 1'b0 || done !== 1'b0 || busy !== 1'b1) spur++;
        end
        cfg_we = 1'b0; ack = 1'b1;
        tick();
        ack = 1'b0;
        chk("layer_cycles", layer_cycles, dly[k]);
        if (k < ne - 1) begin
          tick();
          if (req !== 1'b0 || done !== 1'b0) spur++;
        end
        chk("wait_quiet", spur, 0);
      end
      tick();
      chk("run_done", done, 1);
      chk("run_err", err, 0);
      chk("run_busy", busy, 0);
      chk("cfg_hold", obs_cfg(), model_tab[ne - 1]);
      tick();
      chk("done_pulse", done, 0);
    end
  endtask

  initial begin
    int spur;
    rst = 1'b1; cfg_we = 1'b0; cfg_idx = 3'd0; cfg_desc = '0; start = 1'b0;
    n_layer = 4'd0; abort = 1'b0; ack = 1'b0; pend_we = 1'b0; pend_desc = '0;
    busy_write = 1'b0;
    tick(); tick();
    chk("rst_status", {busy, done, err, req, cur_layer}, 0);
    chk("rst_cycles", layer_cycles, 0);
    chk("rst_cfg", obs_cfg(), 0);
    rst = 1'b0;
    for (int i = 0; i < NL; i++) begin
      model_tab[i] = rand_desc();
      cfg_we = 1'b1; cfg_idx = 3'(i); cfg_desc = model_tab[i];
      tick();
    end
    cfg_we = 1'b0;

    for (int i = 0; i < NL; i++) dly[i] = 50;
    run_layers(3);
    run_layers(0);

    abort = 1'b1; ack = 1'b1;
    tick();
    abort = 1'b0; ack = 1'b0;
    chk("idle_abort", {done, busy, err}, 0);
    chk("idle_ack_cycles", layer_cycles, 50);

    start = 1'b1; n_layer = 4'd1;
    tick();
    start = 1'b0;
    tick();
    chk("to_req", req, 1);
    spur = 0;
    for (int j = 1; j <= TO; j++) begin
      tick();
      if (done !== 1'b0 || busy !== 1'b1) spur++;
    end
    chk("to_early", spur, 0);
    tick();
    chk("to_done", done, 1);
    chk("to_err", err, 1);
    chk("to_busy", busy, 0);
    tick();
    chk("to_pulse", done, 0);
    rand_dly(1, 20);
    run_layers(2);

    start = 1'b1; n_layer = 4'd3;
    tick();
    start = 1'b0;
    tick();
    chk("ab_req0", req, 1);
    repeat (5) tick();
    ack = 1'b1;
    tick();
    ack = 1'b0;
    tick(); tick();
    chk("ab_req1", req, 1);
    chk("ab_layer1", cur_layer, 1);
    repeat (3) tick();
    abort = 1'b1; ack = 1'b1;
    tick();
    abort = 1'b0; ack = 1'b0;
    chk("ab_done", done, 1);
    chk("ab_err", err, 1);
    chk("ab_busy_req", {busy, req}, 0);
    chk("ab_cycles", layer_cycles, 5);
    spur = 0;
    repeat (20) begin
      tick();
      if (req !== 1'b0 || done !== 1'b0 || busy !== 1'b0) spur++;
    end
    chk("ab_quiet", spur, 0);

    pend_we = 1'b1; pend_desc = rand_desc();
    rand_dly(1, 10);
    run_layers(1);

    dly[0] = 10;
    busy_write = 1'b1;
    run_layers(2);
    busy_write = 1'b0;
    run_layers(2);

    start = 1'b1; n_layer = 4'd2;
    tick();
    start = 1'b0;
    tick();
    chk("rs_req", req, 1);
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rs_status", {busy, done, err, req, cur_layer}, 0);
    chk("rs_cycles", layer_cycles, 0);
    chk("rs_cfg", obs_cfg(), 0);
    spur = 0;
    repeat (5) begin
      tick();
      if (done !== 1'b0 || busy !== 1'b0) spur++;
    end
    chk("rs_no_done", spur, 0);
    rand_dly(1, 30);
    run_layers(3);

    rand_dly(1, 8);
    run_layers(12);

    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < NL; i++) begin
        model_tab[i] = rand_desc();
        cfg_we = 1'b1; cfg_idx = 3'(i); cfg_desc = model_tab[i];
        tick();
      end
      cfg_we = 1'b0;
      rand_dly(1, 40);
      run_layers(int'($urandom_range(8, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
